// File: rtl/thread_fetch_scheduler.sv
// Multithreaded fetch front end: per-thread PC/blocked state, round-robin thread pick,
// fetch request (PC, thread id) presented combinationally from registered state.

module thread_fetch_slot #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue,
    input  logic                  pred_take,
    input  logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    input  logic                  block,
    input  logic                  unblock,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  blocked,
    output logic                  blocked_next
);
    // Block dominates a simultaneous unblock.
    assign blocked_next = block | (blocked & ~unblock);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_VAL;
            blocked <= 1'b0;
        end else begin
            blocked <= blocked_next;
            if (redirect)
                pc <= redirect_target;
            else if (issue)
                pc <= pred_take ? pred_target : pc + ADDR_WIDTH'(4);
        end
    end
endmodule

module thread_fetch_scheduler #(
    parameter int                    NUM_THREADS      = 2,
    parameter int                    ADDR_WIDTH       = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC         = 32'h0,
    parameter logic [ADDR_WIDTH-1:0] THREAD_PC_STRIDE = 32'h0010_0000,
    localparam int                   TID_W            = $clog2(NUM_THREADS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_stall,
    input  logic [NUM_THREADS-1:0] i_thread_enable,
    input  logic                   i_pred_valid,
    input  logic                   i_pred_taken,
    input  logic [ADDR_WIDTH-1:0]  i_pred_target,
    input  logic                   i_redirect_valid,
    input  logic [TID_W-1:0]       i_redirect_thread_id,
    input  logic [ADDR_WIDTH-1:0]  i_redirect_target,
    input  logic                   i_block_valid,
    input  logic [TID_W-1:0]       i_block_thread_id,
    input  logic                   i_unblock_valid,
    input  logic [TID_W-1:0]       i_unblock_thread_id,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    output logic [TID_W-1:0]       o_thread_id,
    output logic                   o_valid,
    output logic                   o_fire
);
    logic [NUM_THREADS-1:0][ADDR_WIDTH-1:0] pc_q;
    logic [NUM_THREADS-1:0]                 blocked_q;
    logic [NUM_THREADS-1:0]                 blocked_next;
    logic [NUM_THREADS-1:0]                 elig_next;
    logic [NUM_THREADS-1:0]                 issue_vec;
    logic [NUM_THREADS-1:0]                 redir_vec;
    logic [NUM_THREADS-1:0]                 blk_vec;
    logic [NUM_THREADS-1:0]                 ublk_vec;
    logic [TID_W-1:0]                       sel_q;
    logic [TID_W-1:0]                       sel_next;
    logic                                   found;
    logic                                   pred_take;

    assign o_pc        = pc_q[sel_q];
    assign o_thread_id = sel_q;
    assign o_valid     = i_thread_enable[sel_q] & ~blocked_q[sel_q];
    assign o_fire      = o_valid & ~i_stall;
    assign pred_take   = i_pred_valid & i_pred_taken;

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
        localparam logic [ADDR_WIDTH-1:0] SLOT_RST =
            ADDR_WIDTH'(RESET_PC + THREAD_PC_STRIDE * ADDR_WIDTH'(t));

        assign issue_vec[t] = o_fire && (sel_q == TID_W'(t));
        assign redir_vec[t] = i_redirect_valid && (i_redirect_thread_id == TID_W'(t));
        assign blk_vec[t]   = i_block_valid && (i_block_thread_id == TID_W'(t));
        assign ublk_vec[t]  = i_unblock_valid && (i_unblock_thread_id == TID_W'(t));
        assign elig_next[t] = i_thread_enable[t] & ~blocked_next[t];

        thread_fetch_slot #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .RESET_VAL  (SLOT_RST)
        ) u_slot (
            .clk             (clk),
            .rst_n           (rst_n),
            .issue           (issue_vec[t]),
            .pred_take       (pred_take),
            .pred_target     (i_pred_target),
            .redirect        (redir_vec[t]),
            .redirect_target (i_redirect_target),
            .block           (blk_vec[t]),
            .unblock         (ublk_vec[t]),
            .pc              (pc_q[t]),
            .blocked         (blocked_q[t]),
            .blocked_next    (blocked_next[t])
        );
    end

    // Round-robin search starts after the current pick and ends on it, so a lone
    // eligible thread keeps issuing every cycle.
    always_comb begin
        sel_next = sel_q;
        found    = 1'b0;
        for (int i = 1; i <= NUM_THREADS; i++) begin
            if (!found && elig_next[(int'(sel_q) + i) % NUM_THREADS]) begin
                sel_next = TID_W'((int'(sel_q) + i) % NUM_THREADS);
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sel_q <= '0;
        else if (!i_stall)
            sel_q <= sel_next;
    end
endmodule

// File: tb/tb_thread_fetch_scheduler.sv
// Table-driven bench for thread_fetch_scheduler with a scoreboard of expected fetch outputs.

module tb_thread_fetch_scheduler;
    localparam int NT = 2;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_stall;
    logic [NT-1:0] i_thread_enable;
    logic          i_pred_valid, i_pred_taken;
    logic [AW-1:0] i_pred_target;
    logic          i_redirect_valid;
    logic          i_redirect_thread_id;
    logic [AW-1:0] i_redirect_target;
    logic          i_block_valid, i_block_thread_id;
    logic          i_unblock_valid, i_unblock_thread_id;
    logic [AW-1:0] o_pc;
    logic          o_thread_id;
    logic          o_valid, o_fire;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          st;
        logic [1:0]    en;
        logic          pv, pt;
        logic [31:0]   ptg;
        logic          rv, rt;
        logic [31:0]   rtg;
        logic          bv, bt, uv, ut;
        logic          etid;
        logic [31:0]   epc;
        logic          ev, ef;
    } vec_t;

    typedef struct {
        logic        tid;
        logic [31:0] pc;
        logic        v, f;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    thread_fetch_scheduler #(
        .NUM_THREADS      (NT),
        .ADDR_WIDTH       (AW),
        .RESET_PC         (32'h0),
        .THREAD_PC_STRIDE (32'h0010_0000)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_stall              (i_stall),
        .i_thread_enable      (i_thread_enable),
        .i_pred_valid         (i_pred_valid),
        .i_pred_taken         (i_pred_taken),
        .i_pred_target        (i_pred_target),
        .i_redirect_valid     (i_redirect_valid),
        .i_redirect_thread_id (i_redirect_thread_id),
        .i_redirect_target    (i_redirect_target),
        .i_block_valid        (i_block_valid),
        .i_block_thread_id    (i_block_thread_id),
        .i_unblock_valid      (i_unblock_valid),
        .i_unblock_thread_id  (i_unblock_thread_id),
        .o_pc                 (o_pc),
        .o_thread_id          (o_thread_id),
        .o_valid              (o_valid),
        .o_fire               (o_fire)
    );

    function automatic vec_t mk(input logic st, input logic [1:0] en,
                                input logic pv, input logic pt, input logic [31:0] ptg,
                                input logic rv, input logic rt, input logic [31:0] rtg,
                                input logic bv, input logic bt, input logic uv, input logic ut,
                                input logic etid, input logic [31:0] epc,
                                input logic ev, input logic ef);
        vec_t v;
        v.st = st; v.en = en; v.pv = pv; v.pt = pt; v.ptg = ptg;
        v.rv = rv; v.rt = rt; v.rtg = rtg;
        v.bv = bv; v.bt = bt; v.uv = uv; v.ut = ut;
        v.etid = etid; v.epc = epc; v.ev = ev; v.ef = ef;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%08h want 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic push_exp(input logic tid, input logic [31:0] pc, input logic v, input logic f);
        exp_t e;
        e.tid = tid; e.pc = pc; e.v = v; e.f = f;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int idx);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard step %0d: got empty queue want entry", idx);
            return;
        end
        e = exp_q.pop_front();
        chk("tid",   idx, 32'(o_thread_id), 32'(e.tid));
        chk("pc",    idx, o_pc,             e.pc);
        chk("valid", idx, 32'(o_valid),     32'(e.v));
        chk("fire",  idx, 32'(o_fire),      32'(e.f));
    endtask

    task automatic drive(input vec_t v);
        i_stall              = v.st;
        i_thread_enable      = v.en;
        i_pred_valid         = v.pv;
        i_pred_taken         = v.pt;
        i_pred_target        = v.ptg;
        i_redirect_valid     = v.rv;
        i_redirect_thread_id = v.rt;
        i_redirect_target    = v.rtg;
        i_block_valid        = v.bv;
        i_block_thread_id    = v.bt;
        i_unblock_valid      = v.uv;
        i_unblock_thread_id  = v.ut;
    endtask

    initial begin
        // st  en     pv pt ptg           rv rt rtg           bv bt uv ut  tid pc            v  f
        vecs.push_back(mk(0, 2'b11, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 0, 0,  0, 32'h0,      1, 1));
        vecs.push_back(mk(0, 2'b11, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 0, 0,  1, 32'h100000, 1, 1));
        vecs.push_back(mk(0, 2'b11, 1, 1, 32'h80,     0, 0, 32'h0,         0, 0, 0, 0,  0, 32'h4,      1, 1));
        vecs.push_back(mk(0, 2'b11, 1, 0, 32'h999,    0, 0, 32'h0,         0, 0, 0, 0,  1, 32'h100004, 1, 1));
        vecs.push_back(mk(0, 2'b11, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 0, 0,  0, 32'h80,     1, 1));
        vecs.push_back(mk(0, 2'b11, 1, 1, 32'h300,    1, 1, 32'h200,       0, 0, 0, 0,  1, 32'h100008, 1, 1));
        vecs.push_back(mk(1, 2'b11, 1, 1, 32'h500,    0, 0, 32'h0,         0, 0, 0, 0,  0, 32'h84,     1, 0));
        vecs.push_back(mk(0, 2'b11, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 0, 0,  0, 32'h84,     1, 1));
        vecs.push_back(mk(0, 2'b11, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 0, 0,  1, 32'h200,    1, 1));
        // block t0 under a three-cycle stall
        vecs.push_back(mk(1, 2'b11, 0, 0, 32'h0,      0, 0, 32'h0,         1, 0, 0, 0,  0, 32'h88,     1, 0));
        vecs.push_back(mk(1, 2'b11, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 0, 0,  0, 32'h88,     0, 0));
        vecs.push_back(mk(1, 2'b11, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 0, 0,  0, 32'h88,     0, 0));
        vecs.push_back(mk(0, 2'b11, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 0, 0,  0, 32'h88,     0, 0));
        vecs.push_back(mk(0, 2'b11, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 0, 0,  1, 32'h204,    1, 1));
        vecs.push_back(mk(0, 2'b11, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 1, 0,  1, 32'h208,    1, 1));
        vecs.push_back(mk(0, 2'b11, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 0, 0,  0, 32'h88,     1, 1));
        // all threads disabled, then t1 alone
        vecs.push_back(mk(0, 2'b00, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 0, 0,  1, 32'h20C,    0, 0));
        vecs.push_back(mk(0, 2'b00, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 0, 0,  1, 32'h20C,    0, 0));
        vecs.push_back(mk(0, 2'b10, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 0, 0,  1, 32'h20C,    1, 1));
        // same-cycle block+unblock of t1 leaves it blocked
        vecs.push_back(mk(0, 2'b11, 0, 0, 32'h0,      0, 0, 32'h0,         1, 1, 1, 1,  1, 32'h210,    1, 1));
        vecs.push_back(mk(0, 2'b11, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 0, 0,  0, 32'h8C,     1, 1));
        vecs.push_back(mk(0, 2'b11, 0, 0, 32'h0,      1, 0, 32'hFFFF_FFFC, 0, 0, 0, 0,  0, 32'h90,     1, 1));
        vecs.push_back(mk(0, 2'b11, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 1, 1,  0, 32'hFFFF_FFFC, 1, 1));
        vecs.push_back(mk(0, 2'b11, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 0, 0,  1, 32'h214,    1, 1));
        vecs.push_back(mk(0, 2'b11, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 0, 0,  0, 32'h0,      1, 1));
        vecs.push_back(mk(0, 2'b11, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 0, 0,  1, 32'h218,    1, 1));
        vecs.push_back(mk(0, 2'b11, 0, 0, 32'h0,      0, 0, 32'h0,         0, 0, 0, 0,  0, 32'h4,      1, 1));

        drive(mk(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        #3;
        push_exp(0, 32'h0, 1, 1);
        pop_cmp(-1);
        i_stall = 1'b1;
        #1;
        push_exp(0, 32'h0, 1, 0);
        pop_cmp(-2);
        i_stall = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            push_exp(vecs[i].etid, vecs[i].epc, vecs[i].ev, vecs[i].ef);
            @(negedge clk);
            pop_cmp(i);
            @(posedge clk); #1;
        end

        // Mid-run async reset: sel_q is on t1 here, outputs must snap back at once.
        drive(mk(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push_exp(1, 32'h21C, 1, 1);
        pop_cmp(100);
        #1 rst_n = 1'b0;
        #1;
        push_exp(0, 32'h0, 1, 1);
        pop_cmp(101);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        push_exp(0, 32'h0, 1, 1);
        pop_cmp(102);
        @(posedge clk); #1;
        push_exp(1, 32'h100000, 1, 1);
        @(negedge clk);
        pop_cmp(103);
        @(posedge clk); #1;
        push_exp(0, 32'h4, 1, 1);
        @(negedge clk);
        pop_cmp(104);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
